// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default build parameters.
// Pure declarations; no logic, no latency, no flow control.
package uart_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_RX_FIFO_DEPTH        = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO; head entry visible on rd_dat while rd_vld is high.
// Latency: a write is visible at the head the cycle after it is accepted.
// Backpressure: a write into a full FIFO is dropped and sets sticky overflow, unless a pop occurs in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_vld,
    input  logic [7:0] wr_dat,
    input  logic       rd_rdy,
    output logic       rd_vld,
    output logic [7:0] rd_dat,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  mem_q [DEPTH];
    logic        empty, full, push, pop;

    // Equal pointers mean empty; differing only in the MSB means full.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
        pop      = rd_rdy & ~empty;
        push     = wr_vld & (~full | pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        ovf_d    = ovf_q | (wr_vld & full & ~pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
        end
    end

    assign rd_vld   = ~empty;
    assign rd_dat   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = ovf_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first; optional byte FIFO when UART_RX_FIFO_EN is defined.
// Latency: byte delivered the cycle after the mid-bit stop sample.
// Backpressure: none without FIFO (one-cycle rx_dv pulse); with FIFO, rx_rd pops and a full FIFO drops bytes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = UART_RX_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic       rx_dv,
    output logic [7:0] rx_byte,
    input  logic       rx_rd,
    output logic       frame_err,
    output logic       overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             line;
    logic             deliver;

    assign line = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], rx_serial};
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!line) state_d = START;
            end
            START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = line;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d = '0;
                    if (line) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low break parks here so it reports only one framing error.
                clk_cnt_d = '0;
                if (line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_vld  (deliver),
        .wr_dat  (shift_q),
        .rd_rdy  (rx_rd),
        .rd_vld  (rx_dv),
        .rd_dat  (rx_byte),
        .overflow(overflow)
    );
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    logic       rx_dv_q, rx_dv_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       unused_rd;

    assign unused_rd = rx_rd;

    always_comb begin
        rx_dv_d   = deliver;
        rx_byte_d = deliver ? shift_q : rx_byte_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_dv_q   <= 1'b0;
            rx_byte_q <= 8'h00;
        end else begin
            rx_dv_q   <= rx_dv_d;
            rx_byte_q <= rx_byte_d;
        end
    end

    assign rx_dv    = rx_dv_q;
    assign rx_byte  = rx_byte_q;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit; FIFO scenarios build when UART_RX_FIFO_EN is defined.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
    localparam int H   = (CPB - 1) / 2;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       rx_serial = 1'b1;
    logic       rx_rd     = 1'b0;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       overflow;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_serial(rx_serial),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .rx_rd    (rx_rd),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         dv_cnt       = 0;
    int         ferr_cnt     = 0;
    int         last_dv_cyc  = -1;
    int         t0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
`ifdef UART_RX_FIFO_EN
    logic [7:0] popped_dat;
`endif

    always @(negedge clk) begin
        if (!reset) begin
`ifndef UART_RX_FIFO_EN
            if (rx_dv) begin
                dv_cnt++;
                got_q.push_back(rx_byte);
                last_dv_cyc = cyc;
            end
`endif
            if (frame_err) ferr_cnt++;
        end
    end

    function automatic logic [7:0] pop_got();
        if (got_q.size() == 0) return 8'hxx;
        return got_q.pop_front();
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the last stop-bit edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_in_stop);
        t0 = cyc;
        rx_serial = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_serial = stop;
        for (int i = 0; i < CPB; i++) begin
            rx_rd = pop_in_stop && (cyc == t0 + 3 + H + 9 * CPB);
`ifdef UART_RX_FIFO_EN
            if (rx_rd) popped_dat = rx_byte;
`endif
            @(posedge clk);
            #1;
        end
        rx_rd = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (rx_dv !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_dv got=%b exp=0", rx_dv); end
        tests_run++; if (rx_byte !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(5);
    endtask

`ifndef UART_RX_FIFO_EN
    task automatic test_single;
        int d0, f0;
        logic [7:0] e, g;
        d0 = dv_cnt;
        f0 = ferr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_cycles(4);
        tests_run++; if (dv_cnt - d0 !== 1) begin tests_failed++; $display("FAIL single_dv_cycles got=%0d exp=1", dv_cnt - d0); end
        tests_run++; if (last_dv_cyc !== t0 + 4 + H + 9 * CPB) begin tests_failed++; $display("FAIL single_dv_time got=%0d exp=%0d", last_dv_cyc, t0 + 4 + H + 9 * CPB); end
        tests_run++; if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL single_frame_err got=%0d exp=0", ferr_cnt - f0); end
        tests_run++; if (rx_byte !== 8'hA5) begin tests_failed++; $display("FAIL single_hold got=%h exp=a5", rx_byte); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = pop_got();
            tests_run++; if (g !== e) begin tests_failed++; $display("FAIL single_byte got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_glitch;
        int d0, f0;
        logic [7:0] e, g;
        d0 = dv_cnt;
        f0 = ferr_cnt;
        rx_serial = 1'b0;
        idle_cycles(3);
        rx_serial = 1'b1;
        idle_cycles(3 * CPB);
        tests_run++; if (dv_cnt - d0 !== 0) begin tests_failed++; $display("FAIL glitch_dv got=%0d exp=0", dv_cnt - d0); end
        tests_run++; if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL glitch_frame_err got=%0d exp=0", ferr_cnt - f0); end
        tests_run++; if (dut.state_q !== IDLE) begin tests_failed++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state_q, IDLE); end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle_cycles(4);
        tests_run++; if (dv_cnt - d0 !== 1) begin tests_failed++; $display("FAIL glitch_next_count got=%0d exp=1", dv_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = pop_got();
            tests_run++; if (g !== e) begin tests_failed++; $display("FAIL glitch_next_byte got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_frame_err;
        int d0, f0;
        logic [7:0] e, g;
        d0 = dv_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        idle_cycles(40 * CPB);
        rx_serial = 1'b1;
        idle_cycles(2 * CPB);
        tests_run++; if (ferr_cnt - f0 !== 1) begin tests_failed++; $display("FAIL break_frame_err got=%0d exp=1", ferr_cnt - f0); end
        tests_run++; if (dv_cnt - d0 !== 0) begin tests_failed++; $display("FAIL break_dv got=%0d exp=0", dv_cnt - d0); end
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle_cycles(4);
        tests_run++; if (ferr_cnt - f0 !== 1) begin tests_failed++; $display("FAIL break_after_err got=%0d exp=1", ferr_cnt - f0); end
        tests_run++; if (dv_cnt - d0 !== 1) begin tests_failed++; $display("FAIL break_after_count got=%0d exp=1", dv_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = pop_got();
            tests_run++; if (g !== e) begin tests_failed++; $display("FAIL break_after_byte got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat[6];
        logic [7:0] e, g;
        int d0;
        pat = '{8'h00, 8'hFF, 8'h5A, 8'h96, 8'h00, 8'h01};
        pat[4] = 8'($urandom_range(0, 255));
        d0 = dv_cnt;
        foreach (pat[i]) begin
            exp_q.push_back(pat[i]);
            send_frame(pat[i], 1'b1, 1'b0);
        end
        idle_cycles(4);
        tests_run++; if (dv_cnt - d0 !== 6) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=6", dv_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = pop_got();
            tests_run++; if (g !== e) begin tests_failed++; $display("FAIL b2b_byte got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] c3;
        logic [7:0] e, g;
        int d0, f0;
        c3 = 8'hC3;
        d0 = dv_cnt;
        f0 = ferr_cnt;
        rx_serial = 1'b0;
        idle_cycles(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_serial = c3[i];
            idle_cycles(CPB);
        end
        rx_serial = c3[3];
        idle_cycles(CPB / 2);
        reset = 1'b1;
        rx_serial = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if ({rx_dv, rx_byte, frame_err, overflow} !== 11'd0) begin
                tests_failed++;
                $display("FAIL midreset_outputs got=%b%h%b%b exp=0", rx_dv, rx_byte, frame_err, overflow);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(12 * CPB);
        tests_run++; if (dv_cnt - d0 !== 0) begin tests_failed++; $display("FAIL midreset_delivery got=%0d exp=0", dv_cnt - d0); end
        tests_run++; if (rx_byte !== 8'h00) begin tests_failed++; $display("FAIL midreset_byte got=%h exp=00", rx_byte); end
        tests_run++; if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL midreset_frame_err got=%0d exp=0", ferr_cnt - f0); end
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        idle_cycles(4);
        tests_run++; if (dv_cnt - d0 !== 1) begin tests_failed++; $display("FAIL midreset_next_count got=%0d exp=1", dv_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = pop_got();
            tests_run++; if (g !== e) begin tests_failed++; $display("FAIL midreset_next_byte got=%h exp=%h", g, e); end
        end
    endtask
`else
    task automatic test_fifo_overflow;
        int occ, n;
        logic ovf_exp;
        logic [7:0] e;
        occ = 0;
        ovf_exp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (occ < 16) begin
                exp_q.push_back(8'(i));
                occ++;
            end else begin
                ovf_exp = 1'b1;
            end
        end
        idle_cycles(4);
        tests_run++; if (overflow !== ovf_exp) begin tests_failed++; $display("FAIL ovf_flag got=%b exp=%b", overflow, ovf_exp); end
        tests_run++; if (rx_dv !== 1'b1) begin tests_failed++; $display("FAIL ovf_dv got=%b exp=1", rx_dv); end
        n = 0;
        while (rx_dv === 1'b1 && n < 20) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            tests_run++; if (rx_byte !== e) begin tests_failed++; $display("FAIL ovf_pop_byte got=%h exp=%h", rx_byte, e); end
            rx_rd = 1'b1;
            @(posedge clk);
            #1;
            rx_rd = 1'b0;
            n++;
        end
        tests_run++; if (n !== 16) begin tests_failed++; $display("FAIL ovf_entries got=%0d exp=16", n); end
        tests_run++; if (rx_byte !== 8'h00) begin tests_failed++; $display("FAIL ovf_empty_byte got=%h exp=00", rx_byte); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        exp_q.delete();
    endtask

    task automatic test_fifo_full_push_pop;
        int n;
        logic [7:0] e;
        reset = 1'b1;
        idle_cycles(3);
        reset = 1'b0;
        idle_cycles(3);
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fpp_ovf_reset got=%b exp=0", overflow); end
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(8'h40 + i), 1'b1, 1'b0);
            exp_q.push_back(8'(8'h40 + i));
        end
        send_frame(8'h99, 1'b1, 1'b1);
        e = exp_q.pop_front();
        exp_q.push_back(8'h99);
        tests_run++; if (popped_dat !== e) begin tests_failed++; $display("FAIL fpp_popped got=%h exp=%h", popped_dat, e); end
        idle_cycles(4);
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
        n = 0;
        while (rx_dv === 1'b1 && n < 20) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            tests_run++; if (rx_byte !== e) begin tests_failed++; $display("FAIL fpp_order got=%h exp=%h", rx_byte, e); end
            rx_rd = 1'b1;
            @(posedge clk);
            #1;
            rx_rd = 1'b0;
            n++;
        end
        tests_run++; if (n !== 16) begin tests_failed++; $display("FAIL fpp_occupancy got=%0d exp=16", n); end
        tests_run++; if (rx_dv !== 1'b0) begin tests_failed++; $display("FAIL fpp_empty got=%b exp=0", rx_dv); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef UART_RX_FIFO_EN
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`else
        test_fifo_overflow();
        test_fifo_full_push_pop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, 8N1, LSB first; the receive-side counterpart of the transmitter already driving `uart_tx` in the RGMIIulator top level. Synchronises `uart_rx`, validates the start bit, samples each bit at mid-bit, checks the stop bit, and delivers bytes to the fabric. It gives the top level a host command path, e.g. reset or capture control, alongside the existing hex-dump output path.

## Interface
- `CLKS_PER_BIT`, 868, clk cycles per bit (100 MHz / 115200); legal range 8..65535.
- `FIFO_DEPTH`, 16, byte FIFO depth; power of two. Used only with `UART_RX_FIFO_EN`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_serial`  in  1  raw UART line; asynchronous; idles high.
- `rx_dv`  out  1  byte available; see Configuration.
- `rx_byte`  out  8  received byte.
- `rx_rd`  in  1  pop strobe; ignored without FIFO.
- `frame_err`  out  1  one-cycle pulse on bad stop bit.
- `overflow`  out  1  sticky; set when a byte is dropped because the FIFO is full.

## Operation
- Input passes through a 2-FF synchroniser; both flops reset to 1.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE.
- Bit counter `clk_cnt` is $clog2(CLKS_PER_BIT) bits wide. Bit index is 3 bits.
- IDLE:
  - Synchronised line = 0 → START; clear `clk_cnt`.
- START:
  - Count to H = (CLKS_PER_BIT-1)/2 (integer division), then sample.
  - Sample 0 → DATA, clear `clk_cnt` and bit index.
  - Sample 1 (glitch) → IDLE. No output.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample into `shift[bit_idx]` (LSB first).
  - After bit 7 → STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample.
  - Sample 1 → deliver byte, → IDLE.
  - Sample 0 → pulse `frame_err`, discard byte, → WAIT_IDLE.
- WAIT_IDLE:
  - Stay until synchronised line = 1, then → IDLE.
  - A held-low line (break) therefore yields exactly one `frame_err`.
- Reset at any point, including mid-frame:
  - State → IDLE, counters cleared, partial byte discarded.
  - `rx_dv`=0, `rx_byte`=0, `frame_err`=0, `overflow`=0, FIFO emptied.

## Timing
- T0 = first cycle the synchronised line reads 0. This is 2–3 clk after the raw falling edge.
- Start sample at T0+H+1.
- Data bit n sampled at T0+H+1+(n+1)·CLKS_PER_BIT.
- Stop sample at T0+H+1+9·CLKS_PER_BIT.
- Delivery and `frame_err` are registered: they appear the cycle after the stop sample.
- A new start edge is accepted the cycle after returning to IDLE. Back-to-back frames with a single stop bit receive without loss.
- Tolerates ±4% baud mismatch at CLKS_PER_BIT ≥ 16.

## Configuration
- Macro: `UART_RX_FIFO_EN`.
- Undefined:
  - `rx_dv` is a one-cycle pulse when a byte is delivered.
  - `rx_byte` holds the last good byte until the next delivery.
  - `rx_rd` is ignored; `overflow` is tied 0.
- Defined:
  - Delivered bytes are pushed into a FIFO_DEPTH show-ahead FIFO.
  - `rx_dv` = FIFO non-empty; `rx_byte` = head entry (0 when empty).
  - `rx_rd` with `rx_dv`=1 pops the head. `rx_rd` while empty is ignored.
  - Push and pop in the same cycle on a full FIFO: both happen, no overflow.
  - Push when full without pop: byte dropped, `overflow` set. It stays set until reset.
  - Pointers are log2(FIFO_DEPTH)+1 bits. The MSB distinguishes full from empty; wrap is natural.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, WAIT_IDLE)
  - `UART_DEFAULT_CLKS_PER_BIT` = 868
  - `UART_RX_FIFO_DEPTH` = 16
- Sub-module `uart_rx_fifo`: synchronous show-ahead byte FIFO, instantiated only under `UART_RX_FIFO_EN`. The bit engine stays in `uart_rx`.

## Test plan
- Run the bench with CLKS_PER_BIT=16.
- Single frame 0xA5, ideal timing, no FIFO:
  - `rx_dv` high exactly one cycle at T0+H+1+9·16+1.
  - `rx_byte`=0xA5; `frame_err` never asserts.
- 3-clk low glitch on idle line:
  - No `rx_dv`, no `frame_err`; state back to IDLE.
  - A following 0x3C frame is received correctly.
- Frame 0x55 with stop bit driven 0, line then held low 40 bit times:
  - Exactly one `frame_err` pulse, no `rx_dv`.
  - A subsequent 0x0F after line goes high is received.
- FIFO build, 20 back-to-back frames 0x00..0x13, no reads:
  - 16 entries held; `overflow`=1.
  - Popping yields 0x00..0x0F in order, then `rx_dv`=0.
- Simultaneous push/pop on a full FIFO:
  - Occupancy stays 16; `overflow` stays 0; order preserved.
- `reset` pulsed mid-DATA of 0xC3:
  - All outputs 0 during and after reset; no delivery.
  - A subsequent 0x81 is received correctly.
